// File: rtl/myproject_mac_pipe_n_pkg.sv
// Shared definitions for the pipelined multiply-accumulate block.
//   SAT_WRAP / SAT_CLAMP : narrowing modes for the burst result
//   narrow_t             : {ovf, val} returned by sat_narrow
//   sat_narrow()         : narrows a sign-extended accumulator to dout_w bits
//   mac_params_ok()      : parameter legality check used at elaboration
package myproject_mac_pkg;

  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  // Widest accumulator/result the narrowing helper handles.
  localparam int MAX_W = 64;

  typedef struct packed {
    logic                    ovf;
    logic signed [MAX_W-1:0] val;
  } narrow_t;

  // acc must already be sign-extended to MAX_W. In wrap mode val is acc
  // unchanged, so the caller's low-bit slice is the truncation. In clamp
  // mode values outside the signed dout_w range saturate and flag ovf.
  function automatic narrow_t sat_narrow(input logic signed [MAX_W-1:0] acc,
                                         input int mode,
                                         input int dout_w);
    narrow_t r;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    r.ovf = 1'b0;
    r.val = acc;
    hi    = '0;
    lo    = '0;
    if ((mode == SAT_CLAMP) && (dout_w < MAX_W)) begin
      hi = (MAX_W'(1) << (dout_w - 1)) - MAX_W'(1);
      lo = ~hi;
      if (acc > hi) begin
        r.val = hi;
        r.ovf = 1'b1;
      end else if (acc < lo) begin
        r.val = lo;
        r.ovf = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic bit mac_params_ok(input int din0_w, input int din1_w,
                                       input int din1_signed, input int num_stage,
                                       input int acc_w, input int dout_w,
                                       input int sat_mode);
    return (din0_w >= 2) && (din1_w >= 1) &&
           ((din1_signed == 0) || (din1_signed == 1)) &&
           (num_stage >= 1) && (num_stage <= 4) &&
           (acc_w >= din0_w + din1_w + 1) && (acc_w <= MAX_W) &&
           (dout_w >= 2) && (dout_w <= MAX_W) &&
           ((sat_mode == SAT_WRAP) || (sat_mode == SAT_CLAMP));
  endfunction

endpackage

// File: rtl/myproject_mac_pipe_n_if.sv
// Operand/result bus of the multiply-accumulate block.
//   in_valid/in_first/in_last, din0, din1 : operand beat from the producer
//   out_valid, dout, acc_ovf              : narrowed burst result
// master: stream producer/result consumer; slave: the MAC itself.
interface myproject_mac_pipe_n_if #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 6,
  parameter int DOUT_WIDTH = 22
);
  logic                         in_valid;
  logic                         in_first;
  logic                         in_last;
  logic signed [DIN0_WIDTH-1:0] din0;
  logic        [DIN1_WIDTH-1:0] din1;
  logic                         out_valid;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic                         acc_ovf;

  modport master (
    output in_valid, in_first, in_last, din0, din1,
    input  out_valid, dout, acc_ovf
  );

  modport slave (
    input  in_valid, in_first, in_last, din0, din1,
    output out_valid, dout, acc_ovf
  );
endinterface

// File: rtl/myproject_mac_pipe_n_mul_pipe.sv
// Signed product din0*din1 followed by NUM_STAGE registers.
//   clk, reset (async, active-high), ce (global enable)
//   in_valid/in_first/in_last, din0, din1 : operand beat
//   prod_valid/prod_first/prod_last, prod : delayed product and sidebands
// first/last are qualified by valid on entry so bubbles carry no framing.
module myproject_mul_pipe #(
  parameter  int DIN0_WIDTH  = 16,
  parameter  int DIN1_WIDTH  = 6,
  parameter  int DIN1_SIGNED = 0,
  parameter  int NUM_STAGE   = 2,
  localparam int PROD_W      = DIN0_WIDTH + DIN1_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic        [DIN1_WIDTH-1:0] din1,
  output logic                         prod_valid,
  output logic                         prod_first,
  output logic                         prod_last,
  output logic signed [PROD_W-1:0]     prod
);

  logic signed [DIN1_WIDTH:0]           din1_x;
  logic signed [PROD_W-1:0]             prod_c;
  logic [NUM_STAGE-1:0][PROD_W-1:0]     prod_d, prod_q;
  logic [NUM_STAGE-1:0]                 vld_d, vld_q;
  logic [NUM_STAGE-1:0]                 first_d, first_q;
  logic [NUM_STAGE-1:0]                 last_d, last_q;

  always_comb begin
    // Unsigned din1 gets a zero sign bit so one signed multiplier covers both modes.
    din1_x = (DIN1_SIGNED != 0) ? {din1[DIN1_WIDTH-1], din1} : {1'b0, din1};
    prod_c = PROD_W'(din0) * PROD_W'(din1_x);

    prod_d  = prod_q;
    vld_d   = vld_q;
    first_d = first_q;
    last_d  = last_q;

    prod_d[0]  = prod_c;
    vld_d[0]   = in_valid;
    first_d[0] = in_valid & in_first;
    last_d[0]  = in_valid & in_last;
    for (int i = 1; i < NUM_STAGE; i++) begin
      prod_d[i]  = prod_q[i-1];
      vld_d[i]   = vld_q[i-1];
      first_d[i] = first_q[i-1];
      last_d[i]  = last_q[i-1];
    end
  end

  // Product stages 0..NUM_STAGE-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q  <= '0;
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else if (ce) begin
      prod_q  <= prod_d;
      vld_q   <= vld_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign prod_valid = vld_q[NUM_STAGE-1];
  assign prod_first = first_q[NUM_STAGE-1];
  assign prod_last  = last_q[NUM_STAGE-1];
  assign prod       = $signed(prod_q[NUM_STAGE-1]);

endmodule

// File: rtl/myproject_mac_pipe_n.sv
// Pipelined multiply-accumulate over framed bursts.
//   clk, reset (async, active-high), ce (global enable, 0 freezes everything)
//   bus (slave) : operand beats in, one narrowed sum per burst out
// Product pipe -> accumulator register -> narrowing/output register, so a
// last beat accepted at edge T shows out_valid after edge T+NUM_STAGE+1.
module myproject_mac_pipe_n
  import myproject_mac_pkg::*;
#(
  parameter int DIN0_WIDTH  = 16,
  parameter int DIN1_WIDTH  = 6,
  parameter int DIN1_SIGNED = 0,
  parameter int NUM_STAGE   = 2,
  parameter int ACC_WIDTH   = 32,
  parameter int DOUT_WIDTH  = 22,
  parameter int SAT_MODE    = 0
) (
  input logic                   clk,
  input logic                   reset,
  input logic                   ce,
  myproject_mac_pipe_n_if.slave bus
);

  localparam int PROD_W = DIN0_WIDTH + DIN1_WIDTH + 1;

  if (!mac_params_ok(DIN0_WIDTH, DIN1_WIDTH, DIN1_SIGNED, NUM_STAGE,
                     ACC_WIDTH, DOUT_WIDTH, SAT_MODE)) begin : g_bad_params
    $error("myproject_mac_pipe_n: illegal parameter combination");
  end

  logic                         prod_valid, prod_first, prod_last;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext, sum;
  logic signed [ACC_WIDTH-1:0]  acc_d, acc_q;
  logic                         sticky_d, sticky_q;
  logic                         emit_d, emit_q;
  logic                         out_valid_d, out_valid_q;
  logic                         acc_ovf_d, acc_ovf_q;
  logic signed [DOUT_WIDTH-1:0] dout_d, dout_q;
  narrow_t                      nar;
  logic                         unused_nar;

  myproject_mul_pipe #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .DIN1_SIGNED(DIN1_SIGNED),
    .NUM_STAGE  (NUM_STAGE)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (bus.in_valid),
    .in_first  (bus.in_first),
    .in_last   (bus.in_last),
    .din0      (bus.din0),
    .din1      (bus.din1),
    .prod_valid(prod_valid),
    .prod_first(prod_first),
    .prod_last (prod_last),
    .prod      (prod)
  );

  always_comb begin
    prod_ext = ACC_WIDTH'(prod);
    sum      = acc_q + prod_ext;

    acc_d    = acc_q;
    sticky_d = sticky_q;
    emit_d   = 1'b0;
    if (prod_valid) begin
      if (prod_first) begin
        acc_d    = prod_ext;
        sticky_d = 1'b0;
      end else begin
        acc_d    = sum;
        // Signed overflow: like-signed operands producing an opposite-signed sum.
        sticky_d = sticky_q |
                   ((acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                    (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]));
      end
      emit_d = prod_last;
    end

    nar         = sat_narrow(MAX_W'(acc_q), SAT_MODE, DOUT_WIDTH);
    out_valid_d = emit_q;
    dout_d      = dout_q;
    acc_ovf_d   = acc_ovf_q;
    if (emit_q) begin
      dout_d    = nar.val[DOUT_WIDTH-1:0];
      acc_ovf_d = sticky_q | nar.ovf;
    end
  end

  assign unused_nar = ^nar.val;

  // Accumulator stage, then narrowing/output stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      emit_q      <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      acc_ovf_q   <= 1'b0;
    end else if (ce) begin
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      emit_q      <= emit_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_myproject_mac_pipe_n.sv
// Bench for myproject_mac_pipe_n. Three instances share one stimulus:
//   u_a : unsigned din1, NUM_STAGE=2, wrap
//   u_b : unsigned din1, NUM_STAGE=2, clamp
//   u_c : signed din1,   NUM_STAGE=4, wrap
module tb_myproject_mac_pipe_n;

  logic               clk = 1'b0;
  logic               reset;
  logic               ce;
  logic               in_valid, in_first, in_last;
  logic signed [15:0] din0;
  logic        [5:0]  din1;
  int                 checks = 0;
  int                 errors = 0;

  always #5 clk = ~clk;

  myproject_mac_pipe_n_if #(.DIN0_WIDTH(16), .DIN1_WIDTH(6), .DOUT_WIDTH(22)) if_a ();
  myproject_mac_pipe_n_if #(.DIN0_WIDTH(16), .DIN1_WIDTH(6), .DOUT_WIDTH(22)) if_b ();
  myproject_mac_pipe_n_if #(.DIN0_WIDTH(16), .DIN1_WIDTH(6), .DOUT_WIDTH(22)) if_c ();

  assign if_a.in_valid = in_valid;  assign if_a.in_first = in_first;
  assign if_a.in_last  = in_last;   assign if_a.din0 = din0;  assign if_a.din1 = din1;
  assign if_b.in_valid = in_valid;  assign if_b.in_first = in_first;
  assign if_b.in_last  = in_last;   assign if_b.din0 = din0;  assign if_b.din1 = din1;
  assign if_c.in_valid = in_valid;  assign if_c.in_first = in_first;
  assign if_c.in_last  = in_last;   assign if_c.din0 = din0;  assign if_c.din1 = din1;

  myproject_mac_pipe_n #(.DIN1_SIGNED(0), .NUM_STAGE(2), .SAT_MODE(0))
    u_a (.clk(clk), .reset(reset), .ce(ce), .bus(if_a));
  myproject_mac_pipe_n #(.DIN1_SIGNED(0), .NUM_STAGE(2), .SAT_MODE(1))
    u_b (.clk(clk), .reset(reset), .ce(ce), .bus(if_b));
  myproject_mac_pipe_n #(.DIN1_SIGNED(1), .NUM_STAGE(4), .SAT_MODE(0))
    u_c (.clk(clk), .reset(reset), .ce(ce), .bus(if_c));

  typedef struct {
    int n;   int d0;  int d1;
    int ea;  bit oa;
    int eb;  bit ob;
    int ec;  bit oc;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic beat(input int d0, input int d1, input bit f, input bit l);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    din0     = d0[15:0];
    din1     = d1[5:0];
    tick();
  endtask

  // Idles the input for max_k cycles and records out_valid pulses.
  task automatic collect(input int max_k, output int lat_a, output int lat_c,
                         output int cnt_a, output int cnt_b, output int cnt_c);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    lat_a = -1; lat_c = -1; cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int k = 1; k <= max_k; k++) begin
      tick();
      if (if_a.out_valid === 1'b1) begin cnt_a++; if (lat_a < 0) lat_a = k; end
      if (if_b.out_valid === 1'b1) cnt_b++;
      if (if_c.out_valid === 1'b1) begin cnt_c++; if (lat_c < 0) lat_c = k; end
    end
  endtask

  task automatic check_burst(input string tag, input int ea, input bit oa,
                             input int eb, input bit ob, input int ec, input bit oc);
    int la, lc, ca, cb, cc;
    collect(8, la, lc, ca, cb, cc);
    chk({tag, "/a_pulses"}, ca, 1);
    chk({tag, "/b_pulses"}, cb, 1);
    chk({tag, "/c_pulses"}, cc, 1);
    chk({tag, "/a_latency"}, la, 3);
    chk({tag, "/c_latency"}, lc, 5);
    chk({tag, "/a_dout"}, if_a.dout, ea);
    chk({tag, "/a_ovf"}, if_a.acc_ovf, oa);
    chk({tag, "/b_dout"}, if_b.dout, eb);
    chk({tag, "/b_ovf"}, if_b.acc_ovf, ob);
    chk({tag, "/c_dout"}, if_c.dout, ec);
    chk({tag, "/c_ovf"}, if_c.acc_ovf, oc);
  endtask

  initial begin
    vec_t tbl[8];
    int   la, lc, ca, cb, cc;

    //            n     d0     d1  a_dout    a_ovf b_dout    b_ovf c_dout    c_ovf
    tbl[0] = '{   1,    -3,    63,     -189, 0,     -189, 0,         3, 0};
    tbl[1] = '{   4,  1000,    50,   200000, 0,   200000, 0,    -56000, 0};
    tbl[2] = '{   2, 32767,    63,   -65662, 0,  2097151, 1,    -65534, 0};
    tbl[3] = '{   1,   100,    63,     6300, 0,     6300, 0,      -100, 0};
    tbl[4] = '{   2, -32768,   63,    65536, 0, -2097152, 1,     65536, 0};
    tbl[5] = '{1041, -32768,   63, -1540096, 1,  2097151, 1,    557056, 0};
    tbl[6] = '{   3,    -5,     0,        0, 0,        0, 0,         0, 0};
    tbl[7] = '{   1, 32767,    32,  1048544, 0,  1048544, 0,  -1048544, 0};

    reset = 1'b1; ce = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; din0 = '0; din1 = '0;
    tick();
    tick();
    chk("reset/a_out_valid", if_a.out_valid, 0);
    chk("reset/a_dout", if_a.dout, 0);
    chk("reset/a_ovf", if_a.acc_ovf, 0);
    chk("reset/c_out_valid", if_c.out_valid, 0);
    chk("reset/c_dout", if_c.dout, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < tbl[i].n; b++)
        beat(tbl[i].d0, tbl[i].d1, (b == 0), (b == tbl[i].n - 1));
      check_burst($sformatf("vec%0d", i), tbl[i].ea, tbl[i].oa, tbl[i].eb,
                  tbl[i].ob, tbl[i].ec, tbl[i].oc);
    end

    // Bubbles mid-burst carry junk framing that must be ignored.
    beat(1000, 50, 1'b1, 1'b0);
    beat(1000, 50, 1'b0, 1'b0);
    in_valid = 1'b0; in_first = 1'b1; in_last = 1'b1; din0 = 16'sd999;
    tick();
    tick();
    beat(1000, 50, 1'b0, 1'b0);
    beat(1000, 50, 1'b0, 1'b1);
    check_burst("bubbles", 200000, 0, 200000, 0, -56000, 0);

    // ce low mid-burst with a beat offered, then ce low while out_valid is high.
    beat(1000, 50, 1'b1, 1'b0);
    beat(1000, 50, 1'b0, 1'b0);
    ce = 1'b0;
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; din0 = 16'sd7777; din1 = 6'd9;
    tick(); tick(); tick();
    ce = 1'b1;
    beat(1000, 50, 1'b0, 1'b0);
    beat(1000, 50, 1'b0, 1'b1);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    tick();
    chk("ce/a_early", if_a.out_valid, 0);
    tick();
    tick();
    chk("ce/a_out_valid", if_a.out_valid, 1);
    chk("ce/a_dout", if_a.dout, 200000);
    ce = 1'b0;
    tick();
    tick();
    chk("ce/a_valid_held", if_a.out_valid, 1);
    chk("ce/b_valid_held", if_b.out_valid, 1);
    ce = 1'b1;
    tick();
    chk("ce/a_valid_drop", if_a.out_valid, 0);
    chk("ce/a_dout_hold", if_a.dout, 200000);
    chk("ce/b_dout", if_b.dout, 200000);
    tick(); tick(); tick();
    chk("ce/c_dout", if_c.dout, -56000);

    // Asynchronous reset mid-burst.
    beat(1000, 50, 1'b1, 1'b0);
    beat(1000, 50, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("areset/a_out_valid", if_a.out_valid, 0);
    chk("areset/a_dout", if_a.dout, 0);
    chk("areset/b_dout", if_b.dout, 0);
    chk("areset/c_dout", if_c.dout, 0);
    tick();
    reset = 1'b0;
    collect(8, la, lc, ca, cb, cc);
    chk("areset/a_no_pulse", ca, 0);
    chk("areset/c_no_pulse", cc, 0);
    beat(-3, 63, 1'b1, 1'b1);
    check_burst("after_reset", -189, 0, -189, 0, 3, 0);

    // A new first without a preceding last drops the partial sum.
    beat(1000, 50, 1'b1, 1'b0);
    beat(-3, 63, 1'b1, 1'b1);
    check_burst("restart", -189, 0, -189, 0, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
